// File: rtl/multiplicador_algoritmico.sv
// Sequential signed multiplier: shift-add over operand magnitudes, then a
// two's-complement sign correction of the 2*tamanyo-bit product.
//
// state | meaning
// IDLE  | waiting for Start; registers hold
// SUMA  | conditionally add M into {carry,ACCU} when Q[0]=1
// DESPL | shift {carry,ACCU,Q} right by one, count iterations
// FIN   | register the signed product and pulse Done
module multiplicador_algoritmico #(
  parameter int tamanyo = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Start,
  input  logic [tamanyo-1:0]     A,
  input  logic [tamanyo-1:0]     B,
  output logic [2*tamanyo-1:0]   Prod,
  output logic                   Busy,
  output logic                   Done
);

  localparam int CW = (tamanyo > 1) ? $clog2(tamanyo) : 1;

  typedef enum logic [1:0] {IDLE, SUMA, DESPL, FIN} estado_t;

  estado_t                estado_q;
  logic [tamanyo-1:0]     m_q;
  logic [tamanyo-1:0]     q_q;
  logic [tamanyo-1:0]     accu_q;
  logic                   carry_q;
  logic [CW-1:0]          cont_q;
  logic                   sa_q;
  logic                   sb_q;
  logic [2*tamanyo-1:0]   prod_q;
  logic                   done_q;

  logic [tamanyo-1:0]     abs_a_d;
  logic [tamanyo-1:0]     abs_b_d;
  logic [tamanyo:0]       suma_d;
  logic [2*tamanyo-1:0]   prod_pos_d;
  logic [2*tamanyo-1:0]   prod_neg_d;

  // Magnitudes: -2^(tamanyo-1) negates to itself, which read as unsigned is exact.
  assign abs_a_d    = A[tamanyo-1] ? ('0 - A) : A;
  assign abs_b_d    = B[tamanyo-1] ? ('0 - B) : B;
  assign suma_d     = {1'b0, accu_q} + {1'b0, m_q};
  assign prod_pos_d = {accu_q, q_q};
  assign prod_neg_d = '0 - prod_pos_d;

  // Controller and datapath registers, advanced once per clock.
  always_ff @(posedge CLK) begin
    if (RST) begin
      estado_q <= IDLE;
      m_q      <= '0;
      q_q      <= '0;
      accu_q   <= '0;
      carry_q  <= 1'b0;
      cont_q   <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      prod_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (Start) begin
            m_q      <= abs_a_d;
            q_q      <= abs_b_d;
            sa_q     <= A[tamanyo-1];
            sb_q     <= B[tamanyo-1];
            accu_q   <= '0;
            carry_q  <= 1'b0;
            cont_q   <= CW'(tamanyo - 1);
            estado_q <= SUMA;
          end
        end
        SUMA: begin
          if (q_q[0]) begin
            {carry_q, accu_q} <= suma_d;
          end
          estado_q <= DESPL;
        end
        DESPL: begin
          {carry_q, accu_q, q_q} <= {1'b0, carry_q, accu_q, q_q[tamanyo-1:1]};
          cont_q   <= cont_q - 1'b1;
          estado_q <= (cont_q == '0) ? FIN : SUMA;
        end
        FIN: begin
          prod_q   <= (sa_q ^ sb_q) ? prod_neg_d : prod_pos_d;
          done_q   <= 1'b1;
          estado_q <= IDLE;
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign Prod = prod_q;
  assign Done = done_q;
  assign Busy = (estado_q != IDLE);

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// Bench for multiplicador_algoritmico: one 8-bit instance for directed and
// corner sequences, a bank of 32-bit instances run in lockstep for random
// operands checked against a signed-arithmetic reference.
module tb_multiplicador_algoritmico;

  localparam int NL = 20;
  localparam int NITER = 500;

  logic clk;
  int   checks;
  int   failures;

  logic        rst8, start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  logic          rst32, start32;
  logic [31:0]   a32    [NL];
  logic [31:0]   b32    [NL];
  logic [63:0]   prod32 [NL];
  logic [NL-1:0] busy32;
  logic [NL-1:0] done32;

  multiplicador_algoritmico #(.tamanyo(8)) u_dut8 (
    .CLK(clk), .RST(rst8), .Start(start8), .A(a8), .B(b8),
    .Prod(prod8), .Busy(busy8), .Done(done8)
  );

  for (genvar g = 0; g < NL; g++) begin : g_lane
    multiplicador_algoritmico #(.tamanyo(32)) u_dut32 (
      .CLK(clk), .RST(rst32), .Start(start32), .A(a32[g]), .B(b32[g]),
      .Prod(prod32[g]), .Busy(busy32[g]), .Done(done32[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t tab[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul32(input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return x * y;
  endfunction

  // Caller is 1 time unit after a rising edge. Operands are scrambled right
  // after the sampling edge to show they are not re-read.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output int busyc, output logic [15:0] p);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    busyc = busy8 ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy8) busyc++;
      if (done8) begin
        lat = k;
        break;
      end
    end
    p = prod8;
  endtask

  initial begin
    int lat, busyc, ndone, lat1, lat2;
    logic [15:0] p, p1, p2;
    int lat_l [NL];
    int nd_l  [NL];
    logic [63:0] cap_l [NL];

    checks = 0; failures = 0;
    tab[0] = '{8'h07, 8'hFD, 16'hFFEB};
    tab[1] = '{8'h80, 8'h80, 16'h4000};
    tab[2] = '{8'h80, 8'h7F, 16'hC080};
    tab[3] = '{8'h00, 8'hFB, 16'h0000};
    tab[4] = '{8'hFB, 8'h00, 16'h0000};
    tab[5] = '{8'hFF, 8'hFF, 16'h0001};
    tab[6] = '{8'h7F, 8'h7F, 16'h3F01};
    tab[7] = '{8'hFF, 8'h01, 16'hFFFF};
    tab[8] = '{8'h01, 8'h80, 16'hFF80};

    // Reset with Start held high: must stay idle.
    rst8 = 1'b1; rst32 = 1'b1; start8 = 1'b1; start32 = 1'b0;
    a8 = 8'h07; b8 = 8'h05;
    for (int i = 0; i < NL; i++) begin a32[i] = '0; b32[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_prod", 64'(prod8), 64'd0);
    start8 = 1'b0; rst8 = 1'b0; rst32 = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy8), 64'd0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run8(tab[i].a, tab[i].b, lat, busyc, p);
      chk("tab_prod", 64'(p), 64'(tab[i].p));
      chk("tab_lat", 64'(lat), 64'd17);
      chk("tab_busy", 64'(busyc), 64'd17);
      @(posedge clk); #1;
      chk("tab_done_width", 64'(done8), 64'd0);
    end

    // Start pulsed during cycle 5 with new operands: ignored.
    a8 = 8'h07; b8 = 8'hFD; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0; lat = -1; p = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin start8 = 1'b1; a8 = 8'h02; b8 = 8'h02; end
      if (k == 5) start8 = 1'b0;
      if (done8) begin ndone++; lat = k; p = prod8; end
    end
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_lat", 64'(lat), 64'd17);
    chk("ign_prod", 64'(p), 64'hFFEB);
    chk("ign_idle", 64'(busy8), 64'd0);

    // Reset at cycle 9 of an operation.
    a8 = 8'h80; b8 = 8'h7F; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin @(posedge clk); #1; end
    rst8 = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_prod", 64'(prod8), 64'd0);
    rst8 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin @(posedge clk); #1; if (done8) ndone++; end
    chk("abort_nodone", 64'(ndone), 64'd0);
    chk("abort_prod_hold", 64'(prod8), 64'd0);
    run8(8'hFB, 8'hF9, lat, busyc, p);
    chk("post_abort_prod", 64'(p), 64'h0023);
    chk("post_abort_lat", 64'(lat), 64'd17);

    // Start held high: back-to-back operations, Prod holds between Dones.
    a8 = 8'h03; b8 = 8'h05; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'hFC; b8 = 8'h06;
    ndone = 0; lat1 = -1; lat2 = -1; p1 = '0; p2 = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 18) start8 = 1'b0;
      if (k == 20) chk("hold_prod", 64'(prod8), 64'h000F);
      if (done8) begin
        ndone++;
        if (ndone == 1) begin lat1 = k; p1 = prod8; end
        else begin lat2 = k; p2 = prod8; end
      end
    end
    chk("b2b_ndone", 64'(ndone), 64'd2);
    chk("b2b_lat1", 64'(lat1), 64'd17);
    chk("b2b_prod1", 64'(p1), 64'h000F);
    chk("b2b_lat2", 64'(lat2), 64'd35);
    chk("b2b_prod2", 64'(p2), 64'hFFE8);

    // 32-bit directed corners.
    a32[0] = 32'h8000_0000; b32[0] = 32'd3;
    a32[1] = 32'h8000_0000; b32[1] = 32'h8000_0000;
    for (int i = 2; i < NL; i++) begin a32[i] = 32'(i); b32[i] = 32'hFFFF_FFFF; end
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (done32[0]) begin lat = k; break; end
    end
    chk("w32_lat", 64'(lat), 64'd65);
    chk("w32_minx3", prod32[0], 64'hFFFF_FFFE_8000_0000);
    chk("w32_minxmin", prod32[1], 64'h4000_0000_0000_0000);
    @(posedge clk); #1;

    // 32-bit random operands, all lanes in lockstep.
    for (int it = 0; it < NITER; it++) begin
      for (int i = 0; i < NL; i++) begin
        a32[i] = $urandom;
        b32[i] = $urandom;
        case ($urandom_range(0, 15))
          0: a32[i] = 32'h8000_0000;
          1: b32[i] = 32'h8000_0000;
          2: a32[i] = '0;
          3: b32[i] = 32'hFFFF_FFFF;
          default: ;
        endcase
        lat_l[i] = -1; nd_l[i] = 0;
        cap_l[i] = ref_mul32(a32[i], b32[i]);
      end
      start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      for (int i = 0; i < NL; i++) begin a32[i] = $urandom; b32[i] = $urandom; end
      for (int k = 1; k <= 67; k++) begin
        @(posedge clk); #1;
        for (int i = 0; i < NL; i++) begin
          if (done32[i]) begin
            nd_l[i]++;
            lat_l[i] = k;
          end
        end
      end
      for (int i = 0; i < NL; i++) begin
        chk("rnd_prod", prod32[i], cap_l[i]);
        chk("rnd_lat", 64'(lat_l[i]), 64'd65);
        chk("rnd_ndone", 64'(nd_l[i]), 64'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplicador_algoritmico.md
MULTIPLICADOR_ALGORITMICO -- requirements
Module: multiplicador_algoritmico

Interface
REQ-001 The block SHALL have one parameter: tamanyo, default 32, operand width in bits (minimum 4).
REQ-002 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 Start  input  1  request; sampled only in IDLE.
REQ-005 A  input  tamanyo  signed two's-complement multiplicand.
REQ-006 B  input  tamanyo  signed two's-complement multiplier.
REQ-007 Prod  output  2*tamanyo  signed two's-complement product.
REQ-008 Busy  output  1  high whenever the state is not IDLE.
REQ-009 Done  output  1  one-cycle completion pulse.

Function
REQ-010 The algorithm SHALL be sequential shift-add on magnitudes, followed by sign correction.
- One partial-product step per iteration.
- No combinational full-width multiplier.
REQ-011 The state machine SHALL have four states: IDLE, SUMA, DESPL and FIN.
REQ-012 In IDLE with Start=1, the block SHALL do the following at the sampling edge, then move to SUMA:
- latch |A| into the multiplicand register M;
- latch |B| into the multiplier register Q;
- latch A[msb] and B[msb] as sign flags;
- clear the high accumulator ACCU;
- load the iteration counter CONT with tamanyo-1.
REQ-013 In IDLE with Start=0, the state and every register SHALL hold.
REQ-014 SUMA SHALL add M to ACCU (tamanyo+1 bits, carry kept) when Q[0]=1, otherwise hold ACCU, then move to DESPL.
REQ-015 DESPL SHALL shift {carry,ACCU,Q} right by one, with a zero entering the carry position.
- It SHALL decrement CONT.
- It SHALL move to FIN when CONT was 0, otherwise to SUMA.
REQ-016 FIN SHALL perform three actions, then return to IDLE:
- load Prod with {ACCU,Q}, negated (two's complement) when the sign flags differ;
- set Done=1;
- keep Prod and Done registered.
REQ-017 Latency: Done SHALL be high for exactly the cycle following the edge 2*tamanyo+1 edges after the Start-sampling edge.
- This is 65 edges for tamanyo=32.
- Done SHALL be low on all other cycles.
REQ-018 Prod SHALL hold its value from the Done edge until the next FIN or reset.
- It SHALL not change during a subsequent computation.
REQ-019 Start asserted while Busy=1 SHALL be ignored: no restart and no corruption.
- Start held high SHALL begin a new operation on the first IDLE cycle after FIN.
REQ-020 Operand changes on A and B after the sampling edge SHALL not affect the result.
REQ-021 The most negative operand, -2^(tamanyo-1), SHALL have its magnitude represented exactly as unsigned.
- The product of two such operands (2^(2*tamanyo-2)) SHALL be exact, with no overflow.
REQ-022 A zero result SHALL always be all-zero, independent of the operand signs.

Reset
REQ-023 With RST=1 at a rising edge, the block SHALL go to IDLE from any state, including mid-operation.
- Prod=0, Done=0, Busy=0.
- ACCU, Q, M, CONT and the sign flags SHALL be 0.
REQ-024 While RST=1, Start SHALL be ignored.
- The first operation SHALL be sampled no earlier than the first edge with RST=0.
REQ-025 An operation aborted by reset SHALL produce no Done pulse and leave Prod=0.

Verification
REQ-026 The bench SHALL cover these scenarios, with tamanyo=8 unless stated:
- A=7, B=-3, Start for one cycle -> Done pulse exactly 17 edges later, Prod=-21 (16'hFFEB), Busy high for 17 cycles.
- A=-128, B=-128 -> Prod=16384 (16'h4000); A=-128, B=127 -> Prod=-16256 (16'hC080).
- A=0, B=-5, then A=-5, B=0 -> Prod=0 both times; A=-1, B=-1 -> Prod=1.
- Start pulsed again at cycle 5 of an operation, with new operands A=2, B=2 -> ignored; the first result is delivered unchanged; a single Done pulse.
- RST asserted at cycle 9 of an operation -> next cycle Busy=0, Done=0, Prod=0; no Done pulse; the next Start completes correctly.
- tamanyo=32, A=-2147483648, B=3 -> Done 65 edges after Start, Prod=64'hFFFFFFFE80000000.
- tamanyo=32, randomized operands (at least 10000) -> Prod equals the signed reference product; Done is exactly one cycle wide.
